// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//
// Walks a raster of H_TOTAL x V_TOTAL positions, one position per clock on
// which pix_en is high. Every output is registered and all of them describe
// the same position: sync and bright flags are computed from the position
// about to be loaded, so they never lag the counters.
//
// Ports:
//   clock        system clock, posedge
//   reset        synchronous, active-low
//   pix_en       pixel tick; raster advances one position when high
//   h_sync       horizontal sync, active level H_SYNC_POL
//   v_sync       vertical sync, active level V_SYNC_POL
//   bright       high while the position is inside the visible window
//   h_count      current column, 0..H_TOTAL-1
//   v_count      current line, 0..V_TOTAL-1
//   line_start   one-clock strobe when h_count becomes 0
//   frame_start  one-clock strobe when the position becomes (0,0)
//   frame_count  frames started since reset, modulo 2^FW
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 29,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CW         = 10,
  parameter int unsigned FW         = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pix_en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          bright,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CW < 1 || FW < 1 ||
        ((CW < 32) && ((64'd1 << CW) < 64'(MAX_TOTAL)))) begin : g_param_check
      $fatal(1, "vga_timing_gen: illegal geometry or CW too narrow for totals");
    end
  endgenerate

  // Back porches are at least one wide, so every boundary fits in CW bits.
  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS_END    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          bright_next;
  logic          h_sync_next;
  logic          v_sync_next;

  // Next raster position and the flags belonging to it.
  always_comb begin
    h_wrap = (h_count == H_LAST);
    v_wrap = (v_count == V_LAST);
    h_next = h_wrap ? '0 : h_count + 1'b1;
    v_next = v_count;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v_count + 1'b1;
    end
    bright_next = (h_next < H_VIS_END) && (v_next < V_VIS_END);
    h_sync_next = ((h_next >= H_SYNC_START) && (h_next < H_SYNC_END)) ?
                  H_SYNC_POL : ~H_SYNC_POL;
    v_sync_next = ((v_next >= V_SYNC_START) && (v_next < V_SYNC_END)) ?
                  V_SYNC_POL : ~V_SYNC_POL;
  end

  // Reset parks the raster on its last position so that the first enabled
  // tick lands on (0,0) and raises both strobes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      h_count     <= H_LAST;
      v_count     <= V_LAST;
      bright      <= 1'b0;
      h_sync      <= ~H_SYNC_POL;
      v_sync      <= ~V_SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '1;
    end else if (pix_en) begin
      h_count     <= h_next;
      v_count     <= v_next;
      bright      <= bright_next;
      h_sync      <= h_sync_next;
      v_sync      <= v_sync_next;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_count <= frame_count + 1'b1;
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. It is the successor to the fixed 640x480 generator.
- Produces h/v sync, the bright (display-active) flag, pixel coordinates, line/frame start strobes and a frame counter.
- Timing geometry and sync polarity are set per instance.
- Advances only on a pixel-clock-enable, so it can run from a faster system clock. It sits between the clock/enable source and the pixel/game renderers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- H_SYNC_POL, 0, active level of h_sync (0 = active-low)
- V_SYNC_POL, 0, active level of v_sync
- CW, 10, coordinate width
- FW, 8, frame counter width

Ports:
- clock  in  1  system clock, posedge
- reset  in  1  synchronous, active-low
- pix_en  in  1  pixel tick; the raster advances one position per clock with pix_en=1
- h_sync  out  1  horizontal sync, level per H_SYNC_POL
- v_sync  out  1  vertical sync, level per V_SYNC_POL
- bright  out  1  high while position is in the visible window
- h_count  out  CW  current column, 0..H_TOTAL-1
- v_count  out  CW  current line, 0..V_TOTAL-1
- line_start  out  1  one-clock strobe when h_count becomes 0
- frame_start  out  1  one-clock strobe when position becomes (0,0)
- frame_count  out  FW  frames started since reset, modulo 2^FW

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Defaults give 800x521.
- Elaboration check: every parameter >= 1, and 2^CW >= max(H_TOTAL, V_TOTAL). A violation is a fatal error.
- All outputs are registered and mutually aligned. h_sync, v_sync and bright always describe the position currently on h_count/v_count; there is no one-cycle skew between counts and flags. The flags are therefore computed from the next position.
- Reset (reset=0 at posedge) values:
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1
  - bright = 0; h_sync = !H_SYNC_POL; v_sync = !V_SYNC_POL
  - line_start = 0, frame_start = 0
  - frame_count = all ones
- Reset wins over pix_en. Reset mid-frame takes effect on the next posedge, regardless of position.
- Advance (pix_en=1):
  - if h_count == H_TOTAL-1: h_count -> 0.
    - if also v_count == V_TOTAL-1: v_count -> 0; otherwise v_count -> v_count+1.
  - otherwise h_count -> h_count+1.
- Hold (pix_en=0): counts, syncs and bright keep their value; line_start and frame_start drive 0.
- line_start = 1 for exactly one clock, on the clock the advance lands on h_count=0.
- frame_start = 1 for exactly one clock, on the clock the advance lands on (0,0). line_start is also 1 on that clock.
- frame_count increments on the same clock frame_start asserts. The first frame after reset therefore reports 0. It wraps from 2^FW-1 to 0.
- bright = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- h_sync active iff H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC.
- v_sync active iff V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC. v_sync changes only on clocks where h_count wraps to 0.
- Consequence of reset values: the first enabled tick after reset shows (0,0) with bright=1, line_start=1, frame_start=1, frame_count=0.

Test Plan:
- Defaults, pix_en=1, after reset:
  - first tick -> (0,0), bright=1, both strobes=1, frame_count=0
  - next frame_start exactly 416800 clocks later, with frame_count=1.
- Defaults, one full line:
  - h_sync low exactly for h_count 656..751 (96 clocks)
  - bright high for h_count 0..639 only on lines 0..479
  - v_sync low exactly for lines 490..491.
- pix_en toggled 1,0,1,0:
  - outputs change only after enabled clocks
  - line_start is a single-clock pulse, low during held clocks
  - one line takes 1600 clocks.
- Parameters H=4/1/1/1, V=2/1/1/1, H_SYNC_POL=1, V_SYNC_POL=1, FW=2:
  - totals 7x5; h_sync high only at h=5; v_sync high only on line 3
  - frame_count sequence 0,1,2,3,0 at 35-tick intervals.
- Reset asserted at (300,200) with pix_en=1:
  - next clock shows reset values
  - first enabled tick after release -> (0,0), frame_start=1, frame_count=0.
- pix_en=1 held at (H_TOTAL-1, V_TOTAL-1) boundary:
  - wraps to (0,0) with no intermediate (0, V_TOTAL) or (H_TOTAL, x) value ever visible.
